// File: rtl/mips_mc_ctrl_if.sv
// Control bundle between the multi-cycle MIPS controller and its datapath.
// The master side (controller) drives every select and enable, and the slave side supplies the IR fields and the ALU flag.
interface mips_mc_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       pc_we;
  logic [1:0] pc_sel;
  logic       ir_we;
  logic       reg_we;
  logic [1:0] reg_dst_sel;
  logic       alu_b_sel;
  logic       ext_sel;
  logic [2:0] alu_op;
  logic       mem_we;
  logic       mdr_we;
  logic [1:0] wb_sel;
  logic       instr_done;
  logic [2:0] state;

  modport master (
    input  opcode, funct, zero,
    output pc_we, pc_sel, ir_we, reg_we, reg_dst_sel, alu_b_sel, ext_sel,
           alu_op, mem_we, mdr_we, wb_sel, instr_done, state
  );

  modport slave (
    output opcode, funct, zero,
    input  pc_we, pc_sel, ir_we, reg_we, reg_dst_sel, alu_b_sel, ext_sel,
           alu_op, mem_we, mdr_we, wb_sel, instr_done, state
  );
endinterface

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing for
// addu, subu, ori, lui, lw, sw, beq, j and jal. Every other opcode or funct is retired as a NOP.
module mips_mc_ctrl #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic          clk,
  input  logic          reset,
  mips_mc_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [3:0] WAIT_LD = 4'(MEM_WAIT);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [5:0] op_q, op_d, fn_q, fn_d;
  logic [5:0] cur_op, cur_fn;
  logic       is_addu, is_subu, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
  logic       supported;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= 4'd0;
      op_q    <= 6'd0;
      fn_q    <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      fn_q    <= fn_d;
    end
  end

  // DECODE must act on the live IR fields, since op_q/fn_q only capture them at its end.
  always_comb begin
    cur_op    = (state_q == S_DECODE) ? bus.opcode : op_q;
    cur_fn    = (state_q == S_DECODE) ? bus.funct  : fn_q;
    is_addu   = (cur_op == OP_R) && (cur_fn == FN_ADDU);
    is_subu   = (cur_op == OP_R) && (cur_fn == FN_SUBU);
    is_ori    = (cur_op == OP_ORI);
    is_lui    = (cur_op == OP_LUI);
    is_lw     = (cur_op == OP_LW);
    is_sw     = (cur_op == OP_SW);
    is_beq    = (cur_op == OP_BEQ);
    is_j      = (cur_op == OP_J);
    is_jal    = (cur_op == OP_JAL);
    supported = is_addu | is_subu | is_ori | is_lui | is_lw | is_sw |
                is_beq | is_j | is_jal;
  end

  always_comb begin
    state_d         = S_FETCH;
    cnt_d           = cnt_q;
    op_d            = op_q;
    fn_d            = fn_q;
    bus.pc_we       = 1'b0;
    bus.pc_sel      = 2'b00;
    bus.ir_we       = 1'b0;
    bus.reg_we      = 1'b0;
    bus.reg_dst_sel = 2'b00;
    bus.alu_b_sel   = 1'b0;
    bus.ext_sel     = 1'b0;
    bus.alu_op      = 3'b000;
    bus.mem_we      = 1'b0;
    bus.mdr_we      = 1'b0;
    bus.wb_sel      = 2'b00;
    bus.instr_done  = 1'b0;

    case (state_q)
      S_FETCH: begin
        bus.ir_we = 1'b1;
        bus.pc_we = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        op_d = bus.opcode;
        fn_d = bus.funct;
        if (is_j) begin
          bus.pc_we      = 1'b1;
          bus.pc_sel     = 2'b10;
          bus.instr_done = 1'b1;
          state_d        = S_FETCH;
        end else if (is_jal) begin
          bus.pc_we  = 1'b1;
          bus.pc_sel = 2'b10;
          state_d    = S_WB;
        end else if (!supported) begin
          bus.instr_done = 1'b1;
          state_d        = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_addu || is_subu) begin
          bus.alu_op = is_subu ? 3'b001 : 3'b000;
          state_d    = S_WB;
        end else if (is_ori) begin
          bus.alu_op    = 3'b010;
          bus.alu_b_sel = 1'b1;
          bus.ext_sel   = 1'b1;
          state_d       = S_WB;
        end else if (is_lui) begin
          bus.alu_op    = 3'b011;
          bus.alu_b_sel = 1'b1;
          state_d       = S_WB;
        end else if (is_lw || is_sw) begin
          bus.alu_b_sel = 1'b1;
          cnt_d         = WAIT_LD;
          state_d       = S_MEM;
        end else if (is_beq) begin
          bus.alu_op     = 3'b001;
          bus.pc_sel     = 2'b01;
          bus.pc_we      = bus.zero;
          bus.instr_done = 1'b1;
          state_d        = S_FETCH;
        end
      end
      S_MEM: begin
        // Strobes only in the final wait cycle so slow memory sees one clean pulse.
        if (cnt_q != 4'd0) begin
          cnt_d   = cnt_q - 4'd1;
          state_d = S_MEM;
        end else if (is_sw) begin
          bus.mem_we     = 1'b1;
          bus.instr_done = 1'b1;
          state_d        = S_FETCH;
        end else if (is_lw) begin
          bus.mdr_we = 1'b1;
          state_d    = S_WB;
        end
      end
      S_WB: begin
        bus.reg_we     = 1'b1;
        bus.instr_done = 1'b1;
        if (is_addu || is_subu) begin
          bus.reg_dst_sel = 2'b01;
        end else if (is_lw) begin
          bus.wb_sel = 2'b01;
        end else if (is_jal) begin
          bus.reg_dst_sel = 2'b10;
          bus.wb_sel      = 2'b10;
        end
      end
      default: state_d = S_FETCH;
    endcase

    // Async reset holds the state at FETCH, so the outputs must be squashed explicitly here.
    if (reset) begin
      bus.pc_we       = 1'b0;
      bus.pc_sel      = 2'b00;
      bus.ir_we       = 1'b0;
      bus.reg_we      = 1'b0;
      bus.reg_dst_sel = 2'b00;
      bus.alu_b_sel   = 1'b0;
      bus.ext_sel     = 1'b0;
      bus.alu_op      = 3'b000;
      bus.mem_we      = 1'b0;
      bus.mdr_we      = 1'b0;
      bus.wb_sel      = 2'b00;
      bus.instr_done  = 1'b0;
    end
  end

  assign bus.state = state_q;

endmodule
